// File: rtl/vproc_div_iter.sv
// Restoring radix-2 per-element divider for VDIV/VDIVU/VREM/VREMU.
// Optional VPROC_DIV_EARLY_OUT_EN: finish at accept when |divisor| > |dividend|.
module vproc_div_iter #(
  parameter int unsigned TAG_W = 3
) (
  input  logic             clk_i,
  input  logic             sync_rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_op_i,
  input  logic [1:0]       in_vsew_i,
  input  logic [31:0]      in_op1_i,
  input  logic [31:0]      in_op2_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_res_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic             sgn_in;
  logic             rem_in;
  logic [31:0]      mask_in;
  logic [31:0]      min_in;
  logic [5:0]       n_in;
  logic [31:0]      op1_ext;
  logic [31:0]      op2_ext;
  logic             neg1;
  logic             neg2;
  logic [31:0]      mag1;
  logic [31:0]      mag2;
  logic             div0;
  logic             ovf;
  logic             early;
  logic             special;
  logic [31:0]      spec_res;
  logic             accept;

  logic [TAG_W-1:0] tag_q;
  logic             rem_sel_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic [31:0]      mask_q;
  logic [5:0]       cnt_q;
  logic [31:0]      dvs_q;
  logic [31:0]      quo_q;
  logic [32:0]      rem_q;
  logic [31:0]      res_q;

  logic [33:0]      rem_sh;
  logic [33:0]      diff;
  logic             qbit;
  logic [32:0]      rem_nxt;
  logic [31:0]      quo_nxt;
  logic             last;
  logic [31:0]      fin_q;
  logic [31:0]      fin_r;
  logic [31:0]      fin_res;

  assign sgn_in = in_op_i[0];
  assign rem_in = in_op_i[1];
  assign accept = in_valid_i & (state_q == IDLE);

  always_comb begin
    mask_in = 32'hFFFF_FFFF;
    min_in  = 32'h8000_0000;
    n_in    = 6'd32;
    op1_ext = in_op1_i;
    op2_ext = in_op2_i;
    unique case (in_vsew_i)
      2'b00: begin
        mask_in = 32'h0000_00FF;
        min_in  = 32'hFFFF_FF80;
        n_in    = 6'd8;
        op1_ext = {{24{sgn_in & in_op1_i[7]}}, in_op1_i[7:0]};
        op2_ext = {{24{sgn_in & in_op2_i[7]}}, in_op2_i[7:0]};
      end
      2'b01: begin
        mask_in = 32'h0000_FFFF;
        min_in  = 32'hFFFF_8000;
        n_in    = 6'd16;
        op1_ext = {{16{sgn_in & in_op1_i[15]}}, in_op1_i[15:0]};
        op2_ext = {{16{sgn_in & in_op2_i[15]}}, in_op2_i[15:0]};
      end
      default: begin
        mask_in = 32'hFFFF_FFFF;
        min_in  = 32'h8000_0000;
        n_in    = 6'd32;
        op1_ext = in_op1_i;
        op2_ext = in_op2_i;
      end
    endcase
  end

  assign neg1 = sgn_in & op1_ext[31];
  assign neg2 = sgn_in & op2_ext[31];
  assign mag1 = neg1 ? (~op1_ext + 32'd1) : op1_ext;
  assign mag2 = neg2 ? (~op2_ext + 32'd1) : op2_ext;

  assign div0 = (in_op2_i & mask_in) == 32'd0;
  assign ovf  = sgn_in & (op1_ext == min_in)
              & (op2_ext == 32'hFFFF_FFFF);

`ifdef VPROC_DIV_EARLY_OUT_EN
  assign early = mag2 > mag1;
`else
  assign early = 1'b0;
`endif

  assign special = div0 | ovf | early;

  always_comb begin
    spec_res = 32'd0;
    unique case (1'b1)
      div0:    spec_res = rem_in ? (in_op1_i & mask_in) : mask_in;
      ovf:     spec_res = rem_in ? 32'd0 : (in_op1_i & mask_in);
      early:   spec_res = rem_in ? (in_op1_i & mask_in) : 32'd0;
      default: spec_res = 32'd0;
    endcase
  end

  // Dividend is pre-aligned to bit 31 so every SEW shifts out of the same MSB.
  assign rem_sh  = {rem_q, quo_q[31]};
  assign diff    = rem_sh - {2'b00, dvs_q};
  assign qbit    = ~diff[33];
  assign rem_nxt = qbit ? diff[32:0] : rem_sh[32:0];
  assign quo_nxt = {quo_q[30:0], qbit};
  assign last    = cnt_q == 6'd1;

  assign fin_q   = neg_q_q ? (~quo_nxt + 32'd1) : quo_nxt;
  assign fin_r   = neg_r_q ? (~rem_nxt[31:0] + 32'd1) : rem_nxt[31:0];
  assign fin_res = (rem_sel_q ? fin_r : fin_q) & mask_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid_i) state_d = special ? DONE : CALC;
      CALC: if (last) state_d = DONE;
      DONE: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!sync_rst_ni) begin
      state_q   <= IDLE;
      tag_q     <= '0;
      rem_sel_q <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      mask_q    <= '0;
      cnt_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      res_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tag_q     <= in_tag_i;
        rem_sel_q <= rem_in;
        neg_q_q   <= neg1 ^ neg2;
        neg_r_q   <= neg1;
        mask_q    <= mask_in;
        cnt_q     <= n_in;
        dvs_q     <= mag2;
        quo_q     <= mag1 << (6'd32 - n_in);
        rem_q     <= '0;
        if (special) res_q <= spec_res;
      end else if (state_q == CALC) begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q - 6'd1;
        if (last) res_q <= fin_res;
      end
    end
  end

  assign in_ready_o  = state_q == IDLE;
  assign out_valid_o = state_q == DONE;
  assign busy_o      = state_q != IDLE;
  assign out_res_o   = res_q;
  assign out_tag_o   = tag_q;

endmodule

// File: tb/tb_vproc_div_iter.sv
// Directed bench for vproc_div_iter.
// Latency counts clock edges from the accept edge to out_valid.
module tb_vproc_div_iter;

  logic        clk;
  logic        sync_rst_ni;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [1:0]  in_vsew;
  logic [31:0] in_op1;
  logic [31:0] in_op2;
  logic [2:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [2:0]  out_tag;
  logic        busy;

  int total = 0;
  int bad   = 0;

  vproc_div_iter #(.TAG_W(3)) dut (
    .clk_i       (clk),
    .sync_rst_ni (sync_rst_ni),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_op_i     (in_op),
    .in_vsew_i   (in_vsew),
    .in_op1_i    (in_op1),
    .in_op2_i    (in_op2),
    .in_tag_i    (in_tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_res_o   (out_res),
    .out_tag_o   (out_tag),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic do_op(input string nm, input logic [1:0] op,
                       input logic [1:0] sew, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] tg,
                       input logic [31:0] exp, input int exp_lat);
    int lat;
    chk({nm, "/rdy"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_vsew  = sew;
    in_op1   = a;
    in_op2   = b;
    in_tag   = tg;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op    = ~op;
    in_op1   = 32'hDEAD_BEEF;
    in_op2   = 32'h0000_0005;
    in_tag   = ~tg;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "/lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "/res"}, out_res, exp);
    chk({nm, "/tag"}, {29'd0, out_tag}, {29'd0, tg});
    @(posedge clk);
    #1;
  endtask

  localparam int LAT32 = 33;
`ifdef VPROC_DIV_EARLY_OUT_EN
  localparam int LAT_EO32 = 1;
  localparam int LAT_EO8  = 1;
`else
  localparam int LAT_EO32 = 33;
  localparam int LAT_EO8  = 9;
`endif

  initial begin
    sync_rst_ni = 1'b0;
    in_valid    = 1'b0;
    in_op       = 2'd0;
    in_vsew     = 2'd0;
    in_op1      = 32'd0;
    in_op2      = 32'd0;
    in_tag      = 3'd0;
    out_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst/valid", {31'd0, out_valid}, 32'd0);
    chk("rst/ready", {31'd0, in_ready}, 32'd1);
    chk("rst/res", out_res, 32'd0);
    chk("rst/tag", {29'd0, out_tag}, 32'd0);
    chk("rst/busy", {31'd0, busy}, 32'd0);
    sync_rst_ni = 1'b1;
    @(posedge clk);
    #1;

    do_op("divu32", 2'd0, 2'd2, 32'd100, 32'd7, 3'd5, 32'd14, LAT32);
    do_op("remu32", 2'd2, 2'd2, 32'd100, 32'd7, 3'd1, 32'd2, LAT32);
    do_op("div8", 2'd1, 2'd0, 32'h0000_00F9, 32'h02, 3'd2,
          32'h0000_00FD, 9);
    do_op("rem8", 2'd3, 2'd0, 32'h0000_00F9, 32'h02, 3'd3,
          32'h0000_00FF, 9);
    do_op("divu16z", 2'd0, 2'd1, 32'h0000_1234, 32'd0, 3'd4,
          32'h0000_FFFF, 1);
    do_op("remu16z", 2'd2, 2'd1, 32'h0000_1234, 32'd0, 3'd6,
          32'h0000_1234, 1);
    do_op("div32ovf", 2'd1, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 3'd7,
          32'h8000_0000, 1);
    do_op("rem32ovf", 2'd3, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 3'd0,
          32'd0, 1);
    do_op("div32neg", 2'd1, 2'd2, 32'd7, 32'hFFFF_FFFE, 3'd1,
          32'hFFFF_FFFD, LAT32);
    do_op("rem32neg", 2'd3, 2'd2, 32'd7, 32'hFFFF_FFFE, 3'd2,
          32'd1, LAT32);
    do_op("div16mask", 2'd1, 2'd1, 32'hABCD_FF9C, 32'h1234_0007, 3'd3,
          32'h0000_FFF2, 17);
    do_op("rem16mask", 2'd3, 2'd1, 32'hABCD_FF9C, 32'h1234_0007, 3'd4,
          32'h0000_FFFE, 17);
    do_op("divu_sew3", 2'd0, 2'd3, 32'd100, 32'd7, 3'd5, 32'd14, LAT32);
    do_op("divu32eo", 2'd0, 2'd2, 32'd3, 32'd10, 3'd6, 32'd0, LAT_EO32);
    do_op("remu32eo", 2'd2, 2'd2, 32'd3, 32'd10, 3'd7, 32'd3, LAT_EO32);
    do_op("rem8eo", 2'd3, 2'd0, 32'h0000_00FD, 32'h05, 3'd1,
          32'h0000_00FD, LAT_EO8);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 2'd0;
    in_vsew   = 2'd0;
    in_op1    = 32'd200;
    in_op2    = 32'd3;
    in_tag    = 3'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp/valid", {31'd0, out_valid}, 32'd1);
      chk("bp/res", out_res, 32'h0000_0042);
      chk("bp/tag", {29'd0, out_tag}, 32'd6);
      chk("bp/ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp/valid_after", {31'd0, out_valid}, 32'd0);
    chk("bp/ready_after", {31'd0, in_ready}, 32'd1);
    chk("bp/busy_after", {31'd0, busy}, 32'd0);

    in_valid = 1'b1;
    in_op    = 2'd0;
    in_vsew  = 2'd2;
    in_op1   = 32'd100;
    in_op2   = 32'd7;
    in_tag   = 3'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid/busy", {31'd0, busy}, 32'd1);
    sync_rst_ni = 1'b0;
    @(posedge clk);
    #1;
    chk("mid/valid", {31'd0, out_valid}, 32'd0);
    chk("mid/ready", {31'd0, in_ready}, 32'd1);
    chk("mid/busy0", {31'd0, busy}, 32'd0);
    chk("mid/res", out_res, 32'd0);
    chk("mid/tag", {29'd0, out_tag}, 32'd0);
    sync_rst_ni = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("mid/no_out", {31'd0, out_valid}, 32'd0);

    do_op("post_rst", 2'd2, 2'd0, 32'd50, 32'd7, 3'd2, 32'd1, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
